// File: rtl/shift8_tx.sv
// Serialiser for the shift-register link: takes a word over valid/ready and shifts it out
// one bit per clock, then inserts a programmable 0-3 cycle idle gap.
module shift8_tx #(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] d,
  input  logic              d_valid,
  output logic              d_ready,
  input  logic [1:0]        gap,
  input  logic              msb_first,
  output logic              sout,
  output logic              sout_valid,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StGap
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [1:0]        gap_l_q, gap_l_d;
  logic [1:0]        gap_cnt_q, gap_cnt_d;
  logic              dir_q, dir_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      cnt_q     <= '0;
      gap_l_q   <= '0;
      gap_cnt_q <= '0;
      dir_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      gap_l_q   <= gap_l_d;
      gap_cnt_q <= gap_cnt_d;
      dir_q     <= dir_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    gap_l_d   = gap_l_q;
    gap_cnt_d = gap_cnt_q;
    dir_d     = dir_q;
    unique case (state_q)
      StIdle: begin
        if (d_valid) begin
          shreg_d = d;
          gap_l_d = gap;
          dir_d   = msb_first;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        // Shift toward whichever end drives sout; vacated bits fill with zero.
        shreg_d = dir_q ? (shreg_q << 1) : (shreg_q >> 1);
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == LastBit) begin
          if (gap_l_q != 2'd0) begin
            gap_cnt_d = gap_l_q;
            state_d   = StGap;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        gap_cnt_d = gap_cnt_q - 1'b1;
        if (gap_cnt_q == 2'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // d_ready is held low for as long as reset is asserted, not just until the next edge.
  assign d_ready    = (state_q == StIdle) && !rst;
  assign sout_valid = (state_q == StShift);
  assign busy       = (state_q != StIdle);
  assign sout       = sout_valid & (dir_q ? shreg_q[DATA_W-1] : shreg_q[0]);

endmodule
